// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell shared across every bit position of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sout,
  output logic cout
);

  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s1),   .c(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .s(sout), .c(c2));

  // Only one half adder can carry at a time, so OR gives the majority.
  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR make the full-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fa_cell walks both operands LSB first, one bit per clock,
// behind a valid/ready front end; result is held until the next addition finishes.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry, s, c;
  logic             accept, last_bit;

  fa_cell u_cell (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .sout(s), .cout(c));

  // A 1-bit result has no upper bits to shift down, so it is just the cell sum.
  if (WIDTH == 1) begin : g_r1
    assign r_nxt = s;
  end else begin : g_rn
    assign r_nxt = {s, r_sh[WIDTH-1:1]};
  end

  assign accept   = in_valid & in_ready;
  assign last_bit = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == RUN) || (state == DONE);
    done     = (state == DONE);
  end

  // sum/cout only move on the final RUN edge, so consumers see a stable result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_nxt;
      carry <= c;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        sum  <= r_nxt;
        cout <= c;
      end
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that schedules one shared 1-bit adder cell across all bit positions of two WIDTH-bit operands.
- Processes one bit per clock, LSB first.
- The 1-bit cell is a full adder built from two half_adder instances and an OR gate.
- Sits between a requester with a valid/ready handshake and any consumer of the sum/carry result; trades latency for area.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  requester has an operand pair on a/b.
- in_ready  output  1  controller can accept an operand pair.
- a  input  WIDTH  operand A; sampled only on accept.
- b  input  WIDTH  operand B; sampled only on accept.
- sum  output  WIDTH  registered result, valid when done=1, held afterwards.
- cout  output  1  registered final carry, valid with sum.
- busy  output  1  high while an addition is in progress (RUN or DONE).
- done  output  1  one-cycle pulse: sum/cout updated this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. rst wins over every other event.
- Reset values: state=IDLE, in_ready=1, busy=0, done=0, sum=0, cout=0; internal shift registers, carry and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - Accept = in_valid & in_ready at a rising edge.
  - On accept: load a_sh<=a, b_sh<=b, carry<=0, cnt<=0, r_sh<=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the cell computes s = a_sh[0]^b_sh[0]^carry and c = majority(a_sh[0], b_sh[0], carry).
  - Register updates each cycle: r_sh <= {s, r_sh[WIDTH-1:1]}; a_sh and b_sh shift right one bit; carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1, that cycle's updates complete the result. Go to DONE and load sum<={s, r_sh[WIDTH-1:1]} and cout<=c on the same edge.
- DONE:
  - done=1 for exactly this one cycle, busy=1, in_ready=0.
  - Next state is always IDLE.
- Latency:
  - Accept edge at cycle 0; RUN occupies cycles 1..WIDTH; done is high in cycle WIDTH+1.
  - Next accept is possible at the end of cycle WIDTH+2 (IDLE), giving a throughput of one addition per WIDTH+2 cycles.
- Counter: cnt is $clog2(WIDTH+1) bits wide. For WIDTH=1, RUN lasts exactly one cycle.
- Arithmetic: {cout, sum} == a + b, unsigned, modulo 2^(WIDTH+1). No overflow flag.
- Input handling:
  - in_valid while busy is ignored; a and b are not sampled and nothing is queued.
  - Changes on a/b after the accept edge do not affect the result.
- Output hold: sum/cout change only on the RUN->DONE edge or on rst. They stay stable through IDLE and through the next addition's RUN.
- Reset mid-operation: rst in RUN or DONE aborts the addition, suppresses done, clears sum/cout to 0 and returns to IDLE next cycle.
- in_ready is a combinational decode of state == IDLE, with no dependence on in_valid.

Decomposition:
- Shared package serial_add_pkg:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - localparam MAX_WIDTH=32.
- Sub-module fa_cell:
  - Ports a, b, cin, sout, cout.
  - Two half_adder instances plus an OR of their carries.
  - Instantiated once in serial_add_ctrl.
- The FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
- Reset and first add (WIDTH=8): rst for 2 cycles -> sum=0, cout=0, in_ready=1, busy=0. Then a=0x0F, b=0x01 -> done in cycle 9 after accept with sum=0x10, cout=0.
- Full carry ripple: a=0xFF, b=0x01 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF -> sum=0xFE, cout=1. Check done is exactly one cycle wide.
- Busy rejection: accept 0x12+0x34, then hold in_valid=1 with a=0xAA, b=0x55 during RUN -> in_ready=0 throughout, result 0x46, cout=0. The second pair is accepted only when back in IDLE, giving 0xFF, cout=0.
- Operand stability: change a/b every cycle during RUN -> result equals the values sampled at accept. sum/cout hold their previous values until the RUN->DONE edge.
- Reset mid-run: assert rst at cycle 4 of RUN for 0x80+0x80 -> no done pulse, sum=0, cout=0, IDLE next cycle. A subsequent 0x80+0x80 gives sum=0x00, cout=1.
- Parameter sweep: WIDTH=1 and WIDTH=32 against a random reference model (1000 pairs each) -> {cout, sum}==a+b, done exactly WIDTH+1 cycles after accept.
